// File: rtl/ddr2_ctrl_pkg.sv
// Shared constants for the DDR2 memory-controller front end: app command
// codes, default bus widths and the one-hot read FSM state encodings.
package ddr2_ctrl_pkg;

  localparam logic [2:0] APP_CMD_WRITE = 3'b000;
  localparam logic [2:0] APP_CMD_READ  = 3'b001;

  localparam int ADDR_WIDTH     = 27;
  localparam int APP_DATA_WIDTH = 128;

  localparam int RD_STATE_W = 5;
  localparam logic [RD_STATE_W-1:0] RD_IDLE    = 5'b00001;
  localparam logic [RD_STATE_W-1:0] RD_CMD     = 5'b00010;
  localparam logic [RD_STATE_W-1:0] RD_WAIT    = 5'b00100;
  localparam logic [RD_STATE_W-1:0] RD_ACK     = 5'b01000;
  localparam logic [RD_STATE_W-1:0] RD_RELEASE = 5'b10000;

endpackage

// File: rtl/ddr2_read_control.sv
// DDR2 read-side bridge: turns a bus-master read strobe into a single app
// read command, waits for the returned burst and hands it back with a
// one-cycle ACK_O. A strobe held high after the ACK never re-issues a read.
// Optional macro DDR2_RD_TIMEOUT_EN adds a WAIT-state timeout that pulses
// ERR_O; without it ERR_O is tied low and WAIT waits indefinitely.
module ddr2_read_control #(
  parameter int ADDR_WIDTH     = ddr2_ctrl_pkg::ADDR_WIDTH,
  parameter int APP_DATA_WIDTH = ddr2_ctrl_pkg::APP_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     ADDR_I,
  input  logic                      STB_I,
  input  logic                      read_en,
  output logic [APP_DATA_WIDTH-1:0] DATA_O,
  output logic                      ACK_O,
  output logic                      ERR_O,
  output logic                      app_en,
  output logic [2:0]                app_cmd,
  output logic [ADDR_WIDTH-1:0]     app_addr,
  input  logic                      app_rdy,
  input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
  input  logic                      app_rd_data_valid,
  input  logic                      app_rd_data_end
);

  import ddr2_ctrl_pkg::*;

  logic [RD_STATE_W-1:0] state;
  logic                  dropped;      // strobe fell after the command went out
  logic                  timeout_hit;  // WAIT expired with no data this cycle
  logic                  unused_end;

  // One burst per read at this width, so the end-of-burst flag carries no
  // extra information beyond valid.
  assign unused_end = app_rd_data_end;

  // This block only ever reads.
  assign app_cmd = APP_CMD_READ;

`ifdef DDR2_RD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Valid wins over expiry when both land on the same edge.
  assign timeout_hit = (state == RD_WAIT) && (wait_cnt == CNT_LAST) && !app_rd_data_valid;

  // WAIT-cycle counter: cleared on command acceptance, counts while waiting.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == RD_CMD && app_rdy) begin
      wait_cnt <= '0;
    end else if (state == RD_WAIT && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // One-cycle error pulse on the expiry edge.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      ERR_O <= 1'b0;
    end else begin
      ERR_O <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign ERR_O       = 1'b0;
`endif

  // Read data capture: only a valid beat seen in WAIT updates DATA_O.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      DATA_O <= '0;
    end else if (state == RD_WAIT && app_rd_data_valid) begin
      DATA_O <= app_rd_data;
    end
  end

  // Read FSM: issue, hold until accepted, wait for data, acknowledge, then
  // wait for the strobe to drop before accepting another request.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state    <= RD_IDLE;
      app_en   <= 1'b0;
      app_addr <= '0;
      ACK_O    <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      ACK_O <= 1'b0;
      case (state)
        RD_IDLE: begin
          dropped <= 1'b0;
          if (STB_I && read_en) begin
            app_addr <= ADDR_I;
            app_en   <= 1'b1;
            state    <= RD_CMD;
          end
        end
        RD_CMD: begin
          if (app_rdy) begin
            // Once accepted the read must complete; remember a dropped strobe.
            app_en  <= 1'b0;
            dropped <= !STB_I;
            state   <= RD_WAIT;
          end else if (!STB_I) begin
            app_en <= 1'b0;
            state  <= RD_IDLE;
          end
        end
        RD_WAIT: begin
          if (!STB_I) begin
            dropped <= 1'b1;
          end
          if (app_rd_data_valid) begin
            if (dropped || !STB_I) begin
              state <= RD_RELEASE;
            end else begin
              ACK_O <= 1'b1;
              state <= RD_ACK;
            end
          end else if (timeout_hit) begin
            state <= RD_RELEASE;
          end
        end
        RD_ACK: begin
          state <= RD_RELEASE;
        end
        RD_RELEASE: begin
          if (!STB_I) begin
            state <= RD_IDLE;
          end
        end
        default: begin
          app_en <= 1'b0;
          state  <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_read_control.sv
// Self-checking bench for ddr2_read_control. The reference model is a
// transaction-level view: a sparse memory (address -> burst data) plus the
// last value DATA_O is expected to hold, with per-cycle expectations taken
// from the read protocol rules. Build with DDR2_RD_TIMEOUT_EN defined to
// exercise the timeout path (TIMEOUT_CYCLES is set to 8 here).
module tb_ddr2_read_control;

  localparam int AW = 27;
  localparam int DW = 128;
  localparam int TMO = 8;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ADDR_I = '0;
  logic          STB_I = 1'b0;
  logic          read_en = 1'b0;
  logic [DW-1:0] DATA_O;
  logic          ACK_O;
  logic          ERR_O;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_rdy = 1'b0;
  logic [DW-1:0] app_rd_data = '0;
  logic          app_rd_data_valid = 1'b0;
  logic          app_rd_data_end = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] exp_data = '0;

  ddr2_read_control #(
    .ADDR_WIDTH(AW),
    .APP_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .ADDR_I(ADDR_I),
    .STB_I(STB_I),
    .read_en(read_en),
    .DATA_O(DATA_O),
    .ACK_O(ACK_O),
    .ERR_O(ERR_O),
    .app_en(app_en),
    .app_cmd(app_cmd),
    .app_addr(app_addr),
    .app_rdy(app_rdy),
    .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (!mem.exists(a)) mem[a] = rnd_data();
    return mem[a];
  endfunction

  // One read transaction. rdy_dly: cycles app_rdy stays low in CMD.
  // val_dly: WAIT cycles before data. drop_at: WAIT cycle at which STB_I
  // falls (-1 = never). hold: cycles STB_I stays high after completion.
  task automatic txn(input logic [AW-1:0] addr, input int rdy_dly, input int val_dly,
                     input int drop_at, input int hold);
    logic [DW-1:0] d;
    logic          ack_exp;
    d = mem_read(addr);
    ADDR_I = addr;
    STB_I = 1'b1;
    read_en = 1'b1;
    app_rdy = 1'b0;
    tick();
    for (int i = 0; i <= rdy_dly; i++) begin
      n_checks++;
      if ({app_en, app_addr, app_cmd} !== {1'b1, addr, 3'b001})
        $display("FAIL cmd_hold[%0d]: got en=%b addr=%h cmd=%b want en=1 addr=%h cmd=001",
                 i, app_en, app_addr, app_cmd, addr);
      else n_pass++;
      ADDR_I = AW'($urandom);
      app_rdy = (i == rdy_dly);
      tick();
    end
    app_rdy = 1'b0;
    n_checks++;
    if (app_en !== 1'b0) $display("FAIL cmd_clear: got app_en=%b want 0", app_en);
    else n_pass++;
    for (int j = 0; j < val_dly; j++) begin
      if (j == drop_at) STB_I = 1'b0;
      app_rd_data = rnd_data();
      tick();
      n_checks++;
      if ({ACK_O, app_en, DATA_O} !== {1'b0, 1'b0, exp_data})
        $display("FAIL wait_idle[%0d]: got ack=%b en=%b data=%h want ack=0 en=0 data=%h",
                 j, ACK_O, app_en, DATA_O, exp_data);
      else n_pass++;
    end
    if (drop_at == val_dly) STB_I = 1'b0;
    ack_exp = (drop_at < 0);
    app_rd_data = d;
    app_rd_data_valid = 1'b1;
    app_rd_data_end = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    app_rd_data_end = 1'b0;
    exp_data = d;
    n_checks++;
    if ({ACK_O, ERR_O, DATA_O} !== {ack_exp, 1'b0, exp_data})
      $display("FAIL data_ack: got ack=%b err=%b data=%h want ack=%b err=0 data=%h",
               ACK_O, ERR_O, DATA_O, ack_exp, exp_data);
    else n_pass++;
    tick();
    n_checks++;
    if ({ACK_O, DATA_O} !== {1'b0, exp_data})
      $display("FAIL ack_pulse: got ack=%b data=%h want ack=0 data=%h", ACK_O, DATA_O, exp_data);
    else n_pass++;
    for (int k = 0; k < hold; k++) begin
      tick();
      n_checks++;
      if ({app_en, ACK_O} !== 2'b00)
        $display("FAIL no_reissue[%0d]: got en=%b ack=%b want en=0 ack=0", k, app_en, ACK_O);
      else n_pass++;
    end
    STB_I = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    STB_I = 1'b1;
    read_en = 1'b1;
    ADDR_I = AW'($urandom);
    app_rdy = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({app_en, app_cmd, app_addr, DATA_O, ACK_O, ERR_O} !== {1'b0, 3'b001, {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0})
      $display("FAIL reset_state: got en=%b cmd=%b addr=%h data=%h ack=%b err=%b want 0/001/0/0/0/0",
               app_en, app_cmd, app_addr, DATA_O, ACK_O, ERR_O);
    else n_pass++;
    STB_I = 1'b0;
    app_rdy = 1'b0;
    rst_n = 1'b1;
    exp_data = '0;
    tick();
  endtask

  task automatic test_basic();
    mem[27'h10] = 128'hDEAD_BEEF;
    txn(27'h10, 0, 5, -1, 3);
  endtask

  task automatic test_backpressure();
    txn(27'h2A0, 4, 2, -1, 6);
  endtask

  task automatic test_abort();
    logic [DW-1:0] junk;
    ADDR_I = 27'h55;
    STB_I = 1'b1;
    read_en = 1'b1;
    app_rdy = 1'b0;
    tick();
    n_checks++;
    if (app_en !== 1'b1) $display("FAIL abort_issue: got app_en=%b want 1", app_en);
    else n_pass++;
    STB_I = 1'b0;
    tick();
    n_checks++;
    if ({app_en, ACK_O} !== 2'b00) $display("FAIL abort_clear: got en=%b ack=%b want 0 0", app_en, ACK_O);
    else n_pass++;
    tick();
    junk = rnd_data();
    app_rd_data = junk;
    app_rd_data_valid = 1'b1;
    app_rd_data_end = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    app_rd_data_end = 1'b0;
    n_checks++;
    if ({ACK_O, DATA_O} !== {1'b0, exp_data})
      $display("FAIL stray_valid: got ack=%b data=%h want ack=0 data=%h", ACK_O, DATA_O, exp_data);
    else n_pass++;
    // Drop the strobe inside WAIT: data still lands, no ACK.
    txn(27'h77, 1, 4, 2, 0);
  endtask

  task automatic test_read_en_low();
    int seen;
    seen = 0;
    read_en = 1'b0;
    STB_I = 1'b1;
    ADDR_I = 27'h123;
    for (int i = 0; i < 20; i++) begin
      app_rdy = 1'($urandom);
      tick();
      if (app_en !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL read_en_gate: got %0d cycles with app_en=1 want 0", seen);
    else n_pass++;
    STB_I = 1'b0;
    app_rdy = 1'b0;
    read_en = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    logic [DW-1:0] d;
    int err_early;
    // Case 1: no data ever returns.
    err_early = 0;
    ADDR_I = 27'h300;
    STB_I = 1'b1;
    read_en = 1'b1;
    app_rdy = 1'b1;
    tick();
    tick();
    app_rdy = 1'b0;
`ifdef DDR2_RD_TIMEOUT_EN
    for (int k = 1; k < TMO; k++) begin
      tick();
      if ({ERR_O, ACK_O} !== 2'b00) err_early++;
    end
    n_checks++;
    if (err_early !== 0) $display("FAIL tmo_early: got %0d early err/ack cycles want 0", err_early);
    else n_pass++;
    tick();
    n_checks++;
    if ({ERR_O, ACK_O, DATA_O} !== {1'b1, 1'b0, exp_data})
      $display("FAIL tmo_pulse: got err=%b ack=%b data=%h want err=1 ack=0 data=%h",
               ERR_O, ACK_O, DATA_O, exp_data);
    else n_pass++;
    tick();
    n_checks++;
    if ({ERR_O, app_en} !== 2'b00) $display("FAIL tmo_one_cycle: got err=%b en=%b want 0 0", ERR_O, app_en);
    else n_pass++;
    STB_I = 1'b0;
    tick();
    tick();
    // Case 2: data on the same edge as expiry resolves as a normal read.
    d = rnd_data();
    ADDR_I = 27'h304;
    STB_I = 1'b1;
    app_rdy = 1'b1;
    tick();
    tick();
    app_rdy = 1'b0;
    for (int k = 1; k < TMO; k++) tick();
    app_rd_data = d;
    app_rd_data_valid = 1'b1;
    app_rd_data_end = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    app_rd_data_end = 1'b0;
    exp_data = d;
    n_checks++;
    if ({ACK_O, ERR_O, DATA_O} !== {1'b1, 1'b0, exp_data})
      $display("FAIL tmo_tie: got ack=%b err=%b data=%h want ack=1 err=0 data=%h",
               ACK_O, ERR_O, DATA_O, exp_data);
    else n_pass++;
`else
    for (int k = 0; k < 4 * TMO; k++) begin
      tick();
      if ({ERR_O, ACK_O} !== 2'b00) err_early++;
    end
    n_checks++;
    if (err_early !== 0) $display("FAIL no_timeout: got %0d err/ack cycles want 0", err_early);
    else n_pass++;
    d = rnd_data();
    app_rd_data = d;
    app_rd_data_valid = 1'b1;
    app_rd_data_end = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    app_rd_data_end = 1'b0;
    exp_data = d;
    n_checks++;
    if ({ACK_O, ERR_O, DATA_O} !== {1'b1, 1'b0, exp_data})
      $display("FAIL late_data: got ack=%b err=%b data=%h want ack=1 err=0 data=%h",
               ACK_O, ERR_O, DATA_O, exp_data);
    else n_pass++;
`endif
    tick();
    STB_I = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_inflight();
    // Reset while waiting for data.
    ADDR_I = 27'h4F0;
    STB_I = 1'b1;
    read_en = 1'b1;
    app_rdy = 1'b1;
    tick();
    tick();
    app_rdy = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    STB_I = 1'b0;
    exp_data = '0;
    n_checks++;
    if ({app_en, app_cmd, app_addr, DATA_O, ACK_O, ERR_O} !== {1'b0, 3'b001, {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0})
      $display("FAIL reset_wait: got en=%b cmd=%b addr=%h data=%h ack=%b err=%b want 0/001/0/0/0/0",
               app_en, app_cmd, app_addr, DATA_O, ACK_O, ERR_O);
    else n_pass++;
    // Late data from the killed read must not be captured.
    app_rd_data = rnd_data();
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    n_checks++;
    if ({ACK_O, DATA_O} !== {1'b0, exp_data})
      $display("FAIL reset_stale: got ack=%b data=%h want ack=0 data=%h", ACK_O, DATA_O, exp_data);
    else n_pass++;
    // Reset while a command is pending with app_en high.
    ADDR_I = 27'h4F4;
    STB_I = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    STB_I = 1'b0;
    n_checks++;
    if ({app_en, app_addr} !== {1'b0, {AW{1'b0}}})
      $display("FAIL reset_cmd: got en=%b addr=%h want en=0 addr=0", app_en, app_addr);
    else n_pass++;
    tick();
    txn(27'h4F8, 2, 3, -1, 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int rd, vd, dr, hd;
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 7) << 4);
      rd = $urandom_range(0, 5);
      vd = $urandom_range(0, 7);
      dr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, vd) : -1;
      hd = $urandom_range(0, 4);
      txn(a, rd, vd, dr, hd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_read_en_low();
    test_timeout();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
